// File: rtl/pp_pkg.sv
// Shared definitions for the pp_* read path: group-count formulas and FSM state encoding.
// Used by pp_rd_scheduler and pp_encoder.
`ifndef TOTAL_UART
`define TOTAL_UART 8
`endif
`ifndef TOTAL_GPIO_CTRLS
`define TOTAL_GPIO_CTRLS 8
`endif

package pp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_REQ,
      ST_WAIT_ACK,
      ST_HOLDOFF
   } pp_state_e;

   // Slaves are serviced in groups of four.
   function automatic int unsigned grp_count(input int unsigned n);
      return (n + 3) >> 2;
   endfunction

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pp_rd_scheduler_if.sv
// Read-request handshake between the scheduler (master) and the encoder (slave).
interface pp_rd_scheduler_if #(
   parameter int unsigned TOTAL_GRP = 4
);
   logic                 rd_req;
   logic [TOTAL_GRP-1:0] rd_slave_id;
   logic                 rd_req_ack;

   modport master (output rd_req, output rd_slave_id, input rd_req_ack);
   modport slave  (input rd_req, input rd_slave_id, output rd_req_ack);
endinterface

// File: rtl/pp_rr_pick.sv
// Wrap-around first-one search: lowest set bit of req at or above ptr, modulo N.
module pp_rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   logic [PW-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = PW'((32'(ptr) + i) % N);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/pp_rd_scheduler.sv
// Round-robin read scheduler: grants one group at a time to the encoder,
// waits for the ack (or times out), then holds off one cycle before re-arbitrating.
module pp_rd_scheduler
   import pp_pkg::*;
#(
   parameter int unsigned TOTAL_UART       = `TOTAL_UART,
   parameter int unsigned TOTAL_GPIO_CTRLS = `TOTAL_GPIO_CTRLS,
   parameter int unsigned UART_TOTAL_GRP   = grp_count(TOTAL_UART),
   parameter int unsigned GPIO_TOTAL_GRP   = grp_count(TOTAL_GPIO_CTRLS),
   parameter int unsigned TOTAL_GRP        = UART_TOTAL_GRP + GPIO_TOTAL_GRP,
   parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [TOTAL_GRP-1:0] int_req,
   input  logic                 fifo_afull,
   pp_rd_scheduler_if.master    enc,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [TOTAL_GRP-1:0] err_grp
);

   localparam int unsigned PW = clog2_min1(TOTAL_GRP);
   localparam int unsigned TW = clog2_min1(TIMEOUT_CYCLES);
   localparam logic [TOTAL_GRP-1:0] GRP_ONE = TOTAL_GRP'(1);

   pp_state_e            state_q, state_d;
   logic [PW-1:0]        grant_q, grant_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [TOTAL_GRP-1:0] served_q, served_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [PW-1:0]        err_idx_q, err_idx_d;

   logic [TOTAL_GRP-1:0] eligible;
   logic [TOTAL_GRP-1:0] served_set;
   logic                 pick_valid;
   logic [PW-1:0]        pick_idx;
   logic [PW-1:0]        grant_nxt;

   assign eligible  = int_req & ~served_q;
   assign grant_nxt = (grant_q == PW'(TOTAL_GRP - 1)) ? '0 : grant_q + PW'(1);

   pp_rr_pick #(
      .N  (TOTAL_GRP),
      .PW (PW)
   ) u_pick (
      .req   (eligible),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;
      err_idx_d     = err_idx_q;
      served_set    = '0;
      case (state_q)
         ST_IDLE: begin
            if (en && !fifo_afull && (|eligible)) state_d = ST_ARB;
         end
         ST_ARB: begin
            // Requests may drop between IDLE and ARB; fall back rather than grant nothing.
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            timer_d = '0;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (enc.rd_req_ack) begin
               served_set = GRP_ONE << grant_q;
               rr_ptr_d   = grant_nxt;
               state_d    = ST_HOLDOFF;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               timeout_err_d = 1'b1;
               err_idx_d     = grant_q;
               rr_ptr_d      = grant_nxt;
               state_d       = ST_HOLDOFF;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_HOLDOFF: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      served_d = (served_q | served_set) & int_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         timer_q       <= '0;
         served_q      <= '0;
         timeout_err_q <= 1'b0;
         err_idx_q     <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         timer_q       <= timer_d;
         served_q      <= served_d;
         timeout_err_q <= timeout_err_d;
         err_idx_q     <= err_idx_d;
      end
   end

   assign enc.rd_req      = (state_q == ST_REQ);
   assign enc.rd_slave_id = TOTAL_GRP'(grant_q);
   assign busy            = (state_q != ST_IDLE);
   assign timeout_err     = timeout_err_q;
   assign err_grp         = TOTAL_GRP'(err_idx_q);

endmodule

// File: tb/tb_pp_rd_scheduler.sv
// Directed self-checking bench for pp_rd_scheduler with four groups and a 1024-cycle timeout.
module tb_pp_rd_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] int_req;
   logic       fifo_afull;
   logic       busy;
   logic       timeout_err;
   logic [3:0] err_grp;

   int errors = 0;
   int checks = 0;

   pp_rd_scheduler_if #(.TOTAL_GRP(4)) bus ();

   pp_rd_scheduler #(
      .TOTAL_UART       (8),
      .TOTAL_GPIO_CTRLS (8),
      .TIMEOUT_CYCLES   (1024)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .int_req     (int_req),
      .fifo_afull  (fifo_afull),
      .enc         (bus),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_grp     (err_grp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for rd_req, check the granted id, then check the pulse is one cycle wide.
   task automatic expect_grant(input string tag, input logic [3:0] exp_id, input int max_cyc);
      int n = 0;
      while (!bus.rd_req && n < max_cyc) begin
         tick();
         n++;
      end
      chk({tag, "_seen"}, 32'(bus.rd_req), 32'd1);
      chk({tag, "_id"}, 32'(bus.rd_slave_id), 32'(exp_id));
      tick();
      chk({tag, "_pulse"}, 32'(bus.rd_req), 32'd0);
   endtask

   task automatic do_ack();
      tick();
      bus.rd_req_ack = 1'b1;
      tick();
      bus.rd_req_ack = 1'b0;
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int seen = 0;
      repeat (cycles) begin
         tick();
         if (bus.rd_req) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] order [5];
      order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

      rst            = 1'b1;
      en             = 1'b0;
      int_req        = 4'b0000;
      fifo_afull     = 1'b0;
      bus.rd_req_ack = 1'b0;
      repeat (3) tick();
      chk("rst_rd_req",  32'(bus.rd_req),      32'd0);
      chk("rst_slave",   32'(bus.rd_slave_id), 32'd0);
      chk("rst_busy",    32'(busy),            32'd0);
      chk("rst_timeout", 32'(timeout_err),     32'd0);
      chk("rst_err_grp", 32'(err_grp),         32'd0);

      // Two eligible groups from rr_ptr=0: 1 then 3; first rd_req in the 3rd cycle after reset.
      rst     = 1'b0;
      en      = 1'b1;
      int_req = 4'b1010;
      tick();
      chk("a_arb_no_req", 32'(bus.rd_req), 32'd0);
      chk("a_arb_busy",   32'(busy),       32'd1);
      tick();
      chk("a1_req", 32'(bus.rd_req),      32'd1);
      chk("a1_id",  32'(bus.rd_slave_id), 32'd1);
      tick();
      chk("a1_pulse", 32'(bus.rd_req), 32'd0);
      do_ack();
      chk("a1_holdoff_busy", 32'(busy),       32'd1);
      chk("a1_holdoff_req",  32'(bus.rd_req), 32'd0);
      tick();
      chk("a1_idle_busy", 32'(busy), 32'd0);
      expect_grant("a2", 4'd3, 10);
      do_ack();
      expect_quiet("a_masked", 8);
      int_req = 4'b0000;
      tick();

      // All four requesting, each dropped for a cycle after its ack: pure round robin.
      int_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         expect_grant($sformatf("b%0d", k), order[k], 10);
         do_ack();
         int_req[order[k][1:0]] = 1'b0;
         tick();
         int_req[order[k][1:0]] = 1'b1;
      end
      int_req = 4'b0000;
      tick();

      // Ack arrives on the timeout cycle: counts as an ack, group becomes served.
      int_req = 4'b0100;
      expect_grant("d", 4'd2, 10);
      repeat (1023) tick();
      bus.rd_req_ack = 1'b1;
      tick();
      bus.rd_req_ack = 1'b0;
      chk("d_no_timeout", 32'(timeout_err), 32'd0);
      chk("d_err_grp",    32'(err_grp),     32'd0);
      expect_quiet("d_served_masked", 10);
      int_req = 4'b0000;
      tick();

      // No ack: timeout after 1024 cycles in WAIT_ACK, pointer moves past group 2.
      int_req = 4'b0100;
      expect_grant("c", 4'd2, 10);
      repeat (1023) tick();
      chk("c_before_timeout", 32'(timeout_err), 32'd0);
      tick();
      chk("c_timeout",  32'(timeout_err), 32'd1);
      chk("c_err_grp",  32'(err_grp),     32'd2);
      chk("c_holdoff",  32'(busy),        32'd1);
      int_req = 4'b1100;
      expect_grant("c_next", 4'd3, 10);
      do_ack();
      chk("c_sticky", 32'(timeout_err), 32'd1);
      int_req = 4'b0000;
      tick();

      // fifo_afull blocks grants; rd_req follows two cycles after it drops.
      fifo_afull = 1'b1;
      int_req    = 4'b0001;
      expect_quiet("e_afull_quiet", 6);
      fifo_afull = 1'b0;
      tick();
      chk("e_arb_no_req", 32'(bus.rd_req), 32'd0);
      tick();
      chk("e_req", 32'(bus.rd_req),      32'd1);
      chk("e_id",  32'(bus.rd_slave_id), 32'd0);
      tick();
      // Gating inputs change mid-transaction; the transaction still completes.
      en         = 1'b0;
      fifo_afull = 1'b1;
      do_ack();
      chk("e_inflight_holdoff", 32'(busy), 32'd1);
      tick();
      chk("e_inflight_idle", 32'(busy), 32'd0);
      en         = 1'b1;
      fifo_afull = 1'b0;
      int_req    = 4'b0000;
      tick();

      // Reset during WAIT_ACK, then a stale ack must be ignored.
      int_req = 4'b0010;
      expect_grant("f", 4'd1, 10);
      rst = 1'b1;
      tick();
      chk("f_rst_req",     32'(bus.rd_req),      32'd0);
      chk("f_rst_slave",   32'(bus.rd_slave_id), 32'd0);
      chk("f_rst_busy",    32'(busy),            32'd0);
      chk("f_rst_timeout", 32'(timeout_err),     32'd0);
      chk("f_rst_err_grp", 32'(err_grp),         32'd0);
      rst            = 1'b0;
      int_req        = 4'b0000;
      bus.rd_req_ack = 1'b1;
      tick();
      bus.rd_req_ack = 1'b0;
      chk("f_stale_busy", 32'(busy),       32'd0);
      chk("f_stale_req",  32'(bus.rd_req), 32'd0);
      int_req = 4'b0001;
      expect_grant("f_after", 4'd0, 10);
      do_ack();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
